// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver. The serial line is synchronised, a start bit is
// confirmed at its centre, then data, optional parity and stop bits are sampled
// at the centre of each bit cell. Each word is delivered as a one-cycle
// rx_valid strobe with parity and framing flags that hold until the next word.
module uart_rx_oversample #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t         state, state_n;
  logic           sync1, rx_s;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IW-1:0]  idx, idx_n;
  logic [N-1:0]   shreg, shreg_n;
  logic           perr, perr_n;
  logic           stop_smp, stop_smp_n;
  // stop_done marks the one cycle between the stop sample and word delivery
  logic           stop_done, stop_done_n;
  logic [N-1:0]   rx_data_n;
  logic           rx_valid_n, parity_err_n, frame_err_n;

  // Two-flop synchroniser; reset high so the line looks idle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX;
      rx_s  <= sync1;
    end
  end

  // State, bit timer, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      stop_smp   <= 1'b0;
      stop_done  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      perr       <= perr_n;
      stop_smp   <= stop_smp_n;
      stop_done  <= stop_done_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  // Next-state and sampling decisions
  always_comb begin
    state_n      = state;
    cnt_n        = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    idx_n        = idx;
    shreg_n      = shreg;
    perr_n       = perr;
    stop_smp_n   = stop_smp;
    stop_done_n  = stop_done;
    rx_data_n    = rx_data;
    rx_valid_n   = 1'b0;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_n   = '0;
          idx_n   = '0;
          // a line already back high at mid-start was only a glitch
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_MAX) begin
          shreg_n[idx] = rx_s;
          if (idx == IDX_LAST) state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else                 idx_n   = idx + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_MAX) begin
          perr_n  = ^shreg ^ rx_s ^ 1'(PARITY_ODD);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!stop_done) begin
          if (cnt == CNT_MAX) begin
            stop_smp_n  = rx_s;
            stop_done_n = 1'b1;
          end
        end else begin
          stop_done_n  = 1'b0;
          rx_valid_n   = 1'b1;
          rx_data_n    = shreg;
          parity_err_n = (PARITY_EN != 0) ? perr : 1'b0;
          frame_err_n  = !stop_smp;
          // a low stop bit parks in BREAK so a held-low line yields one word
          state_n      = stop_smp ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: a default-parameter instance (dut0)
// and a fast no-parity instance (dut1) for back-to-back frames.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, pe0, fe0, b0;
  logic       v1, pe1, fe1, b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         q0_cyc[$], q1_cyc[$];
  logic [7:0] q0_dat[$], q1_dat[$];
  logic       q0_pe[$], q0_fe[$], q1_pe[$], q1_fe[$];

  uart_rx_oversample #(.N(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .rx_data(d0), .rx_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0));

  uart_rx_oversample #(.N(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .rx_data(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe with the posedge count at which it became visible
  always @(negedge clk) begin
    if (v0) begin
      q0_cyc.push_back(cyc); q0_dat.push_back(d0);
      q0_pe.push_back(pe0);  q0_fe.push_back(fe0);
    end
    if (v1) begin
      q1_cyc.push_back(cyc); q1_dat.push_back(d1);
      q1_pe.push_back(pe1);  q1_fe.push_back(fe1);
    end
  end

  function automatic logic [31:0] mk_frame(input logic [7:0] d, input logic par,
                                           input logic stp, input bit with_par);
    logic [31:0] f;
    f = '0;
    if (with_par) f[10:0] = {stp, par, d, 1'b0};
    else          f[9:0]  = {stp, d, 1'b0};
    return f;
  endfunction

  // Drive nbits LSB first, cpb cycles each; c0 is the posedge count just
  // before the start bit, so edge 0 is posedge c0+1. The line is left at the
  // last bit's level.
  task automatic send_bits(input int dut, input logic [31:0] bits, input int nbits,
                           input int cpb, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < nbits; i++) begin
      if (dut == 0) rx0 = bits[i]; else rx1 = bits[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    q0_cyc.delete(); q0_dat.delete(); q0_pe.delete(); q0_fe.delete();
    q1_cyc.delete(); q1_dat.delete(); q1_pe.delete(); q1_fe.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", d0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", v0); end
    checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", pe0); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", fe0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b0); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", b1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", b0); end
  endtask

  task automatic test_good_frame();
    int c0;
    clear_queues();
    send_bits(0, mk_frame(8'hA5, 1'b0, 1'b1, 1), 11, 16, c0);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL good_count: got %0d want 1", q0_cyc.size()); end
    if (q0_cyc.size() >= 1) begin
      checks++; if (q0_cyc[0] !== c0 + 172) begin errors++; $display("FAIL good_latency: got edge %0d want 171", q0_cyc[0] - c0 - 1); end
      checks++; if (q0_dat[0] !== 8'hA5) begin errors++; $display("FAIL good_data: got %h want a5", q0_dat[0]); end
      checks++; if (q0_pe[0] !== 1'b0) begin errors++; $display("FAIL good_parity_err: got %b want 0", q0_pe[0]); end
      checks++; if (q0_fe[0] !== 1'b0) begin errors++; $display("FAIL good_frame_err: got %b want 0", q0_fe[0]); end
    end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b want 0", b0); end
  endtask

  task automatic test_parity_err();
    int c0;
    clear_queues();
    send_bits(0, mk_frame(8'h3C, 1'b1, 1'b1, 1), 11, 16, c0);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL par_count: got %0d want 1", q0_cyc.size()); end
    if (q0_cyc.size() >= 1) begin
      checks++; if (q0_dat[0] !== 8'h3C) begin errors++; $display("FAIL par_data: got %h want 3c", q0_dat[0]); end
      checks++; if (q0_pe[0] !== 1'b1) begin errors++; $display("FAIL par_parity_err: got %b want 1", q0_pe[0]); end
      checks++; if (q0_fe[0] !== 1'b0) begin errors++; $display("FAIL par_frame_err: got %b want 0", q0_fe[0]); end
    end
    // flags hold after the strobe
    checks++; if (pe0 !== 1'b1) begin errors++; $display("FAIL par_flag_hold: got %b want 1", pe0); end
  endtask

  task automatic test_break();
    int c0;
    clear_queues();
    send_bits(0, mk_frame(8'hFF, 1'b0, 1'b0, 1), 11, 16, c0);
    rx0 = 1'b0;
    repeat (40 * 16) @(posedge clk);
    #1;
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL brk_busy_held: got %b want 1", b0); end
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL brk_count: got %0d want 1", q0_cyc.size()); end
    if (q0_cyc.size() >= 1) begin
      checks++; if (q0_cyc[0] !== c0 + 172) begin errors++; $display("FAIL brk_latency: got edge %0d want 171", q0_cyc[0] - c0 - 1); end
      checks++; if (q0_dat[0] !== 8'hFF) begin errors++; $display("FAIL brk_data: got %h want ff", q0_dat[0]); end
      checks++; if (q0_fe[0] !== 1'b1) begin errors++; $display("FAIL brk_frame_err: got %b want 1", q0_fe[0]); end
      checks++; if (q0_pe[0] !== 1'b0) begin errors++; $display("FAIL brk_parity_err: got %b want 0", q0_pe[0]); end
    end
    rx0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL brk_busy_exit: got %b want 0", b0); end
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL brk_count_after: got %0d want 1", q0_cyc.size()); end
  endtask

  task automatic test_glitch();
    int c0;
    clear_queues();
    @(posedge clk); #1;
    c0 = cyc;
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (5) @(posedge clk);   // now just past edge 9
    @(negedge clk);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_e9: got %b want 1", b0); end
    @(negedge clk);              // just past edge 10
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_e10: got %b want 0", b0); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 0) begin errors++; $display("FAIL glitch_no_strobe: got %0d want 0", q0_cyc.size()); end
    send_bits(0, mk_frame(8'h12, 1'b0, 1'b1, 1), 11, 16, c0);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d want 1", q0_cyc.size()); end
    if (q0_cyc.size() >= 1) begin
      checks++; if (q0_dat[0] !== 8'h12) begin errors++; $display("FAIL glitch_next_data: got %h want 12", q0_dat[0]); end
      checks++; if (q0_pe[0] !== 1'b0 || q0_fe[0] !== 1'b0) begin errors++; $display("FAIL glitch_next_flags: got pe=%b fe=%b want 0 0", q0_pe[0], q0_fe[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    logic [31:0] f;
    clear_queues();
    f = mk_frame(8'h5A, 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    // start bit, data bits 0..2, then half of data bit 3
    for (int i = 0; i < 16 * 4 + 8; i++) begin
      rx0 = f[i / 16];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", d0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", b0); end
    checks++; if (v0 !== 1'b0 || pe0 !== 1'b0 || fe0 !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got v=%b pe=%b fe=%b want 0 0 0", v0, pe0, fe0); end
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 0) begin errors++; $display("FAIL rst_mid_no_strobe: got %0d want 0", q0_cyc.size()); end
    send_bits(0, mk_frame(8'h81, 1'b0, 1'b1, 1), 11, 16, c0);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (q0_cyc.size() !== 1) begin errors++; $display("FAIL rst_next_count: got %0d want 1", q0_cyc.size()); end
    if (q0_cyc.size() >= 1) begin
      checks++; if (q0_dat[0] !== 8'h81) begin errors++; $display("FAIL rst_next_data: got %h want 81", q0_dat[0]); end
      checks++; if (q0_pe[0] !== 1'b0 || q0_fe[0] !== 1'b0) begin errors++; $display("FAIL rst_next_flags: got pe=%b fe=%b want 0 0", q0_pe[0], q0_fe[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] b;
    logic [7:0] dat [3];
    dat = '{8'h00, 8'h55, 8'hAA};
    clear_queues();
    b = '0;
    for (int f = 0; f < 3; f++) begin
      b[f*10]        = 1'b0;
      b[f*10+1 +: 8] = dat[f];
      b[f*10+9]      = 1'b1;
    end
    send_bits(1, b, 30, 4, c0);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (q1_cyc.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", q1_cyc.size()); end
    for (int i = 0; i < q1_cyc.size() && i < 3; i++) begin
      // L = 3 + 2 + 9*4 = 41, frames 40 cycles apart
      checks++; if (q1_cyc[i] !== c0 + 42 + 40 * i) begin errors++; $display("FAIL b2b_time%0d: got edge %0d want %0d", i, q1_cyc[i] - c0 - 1, 41 + 40 * i); end
      checks++; if (q1_dat[i] !== dat[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, q1_dat[i], dat[i]); end
      checks++; if (q1_pe[i] !== 1'b0 || q1_fe[i] !== 1'b0) begin errors++; $display("FAIL b2b_flags%0d: got pe=%b fe=%b want 0 0", i, q1_pe[i], q1_fe[i]); end
    end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b want 0", b1); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

Oversampling UART receiver: the consumer at the far end of a UART TX line. It synchronises the asynchronous serial input, detects the start bit, samples each bit at its centre, and checks optional parity and the stop bit. It delivers each received word to the local logic as a one-cycle strobe with error flags. It is the receive-side stage paired with the UART transmit/connect blocks.

## Interface
- N, 8: data bits per frame, LSB first, N ≥ 5.
- CLKS_PER_BIT, 16: clk cycles per serial bit; even, ≥ 4.
- PARITY_EN, 1: 1 = one parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RX  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  N  last received data word; holds until the next rx_valid.
- rx_valid  output  1  one-cycle strobe; rx_data and the flags are valid in this cycle.
- parity_err  output  1  parity mismatch for the current word; qualified by rx_valid.
- frame_err  output  1  stop bit sampled 0; qualified by rx_valid.
- busy  output  1  high in every state except IDLE.

## Operation
- RX passes through a 2-FF synchroniser to form rx_s. Both FFs reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. One bit-timer cnt, 0..CLKS_PER_BIT-1. One bit index, 0..N-1.
- IDLE: when rx_s = 0, go to START and clear cnt.
- START: when cnt = CLKS_PER_BIT/2-1 (mid start bit):
  - rx_s = 1: false start. Return to IDLE with no strobe and no flags.
  - rx_s = 0: go to DATA with cnt = 0 and index = 0.
- DATA: when cnt = CLKS_PER_BIT-1, shift rx_s into the data register at position index. After index N-1, go to PARITY if PARITY_EN = 1, else go to STOP.
- PARITY: sample at cnt = CLKS_PER_BIT-1. Compute perr = (^data ^ sample ^ PARITY_ODD).
- STOP: sample at cnt = CLKS_PER_BIT-1. On the next edge:
  - load rx_data;
  - pulse rx_valid;
  - set parity_err = perr (0 when PARITY_EN = 0);
  - set frame_err = !stop_sample.
- After STOP:
  - stop sample = 1: go to IDLE.
  - stop sample = 0: go to BREAK. Stay in BREAK until rx_s = 1, then go to IDLE. A held-low line yields exactly one word.
- Frames carrying errors are still delivered; the flags qualify them.
- parity_err and frame_err hold their values until the next rx_valid.
- No internal buffering. The consumer must take the word in the rx_valid cycle.
- Reset mid-frame: the frame in progress is discarded and no strobe is produced. Reception resumes only after rx_s is seen high and then a new falling edge occurs; the synchroniser reset to 1 guarantees this.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0, FSM = IDLE, synchroniser = 1.
- Edge numbering: edge 0 is the clk edge at which sync FF1 first captures RX = 0. FSM enters START at edge 2, and busy rises after edge 2.
- Mid-start sample is at edge 2 + CLKS_PER_BIT/2.
- Data bit k is sampled at edge 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- The parity sample follows the data samples by CLKS_PER_BIT, and the stop sample follows by a further CLKS_PER_BIT.
- rx_valid rises at edge L = 3 + CLKS_PER_BIT/2 + (N+PARITY_EN+1)·CLKS_PER_BIT. With the defaults, L = 171.
- busy falls in the rx_valid cycle when the stop bit is good, and at BREAK exit otherwise.
- Back-to-back frames: a start edge arriving in the cycle after STOP is accepted, so no idle bit is required between frames.
- rx_valid is high for exactly one cycle and never on consecutive cycles.

## Test plan
- Defaults; send 0xA5 with parity bit 0 and stop bit 1 → rx_valid at edge 171, rx_data = 0xA5, parity_err = 0, frame_err = 0.
- Send 0x3C with parity bit 1 (wrong for even parity) → rx_data = 0x3C, parity_err = 1, frame_err = 0.
- Send 0xFF with stop bit 0, then hold RX low for 40 bit times → exactly one strobe with rx_data = 0xFF and frame_err = 1; busy stays high until RX returns high.
- Drive a 5-cycle low glitch on an idle line → no rx_valid, busy returns to 0 at edge 10, and a following frame 0x12 is received correctly.
- Assert rst_n low during data bit 3 of a frame, release it, then send 0x81 → no strobe for the aborted frame, one strobe with 0x81, and all outputs 0 while in reset.
- Send three back-to-back frames with no idle gap (0x00, 0x55, 0xAA), PARITY_EN = 0, CLKS_PER_BIT = 4 → three strobes exactly 4·10 = 40 cycles apart with the correct data.
